ibex_pext_issue: RTL and testbench
==================================

Name: ibex_pext_issue

Overview:
- Issue/sequencing stage directly upstream of the P-extension ALU and multiplier.
- Accepts one P-ext op from the decoder over a valid/ready handshake and registers the operands.
- Drives the ALU and multiplier for the required number of cycles, then captures the ALU result and the saturation (OV) flag.
- Presents the result to writeback on a valid/ready handshake and maintains the sticky OV (vxsat) CSR bit.

Parameters:
- MultCycles, 2: cycles mult_en_o is held for multiplier ops, range 1..15.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- valid_i  in  1  decoder presents an op
- ready_o  out  1  issue stage can accept
- kill_i  in  1  flush in-flight op
- operator_i  in  zpn_op_e  P-ext operator
- signed_operands_i  in  signed_type_e  element type/signedness
- operand_a_i  in  32  rs1
- operand_b_i  in  32  rs2
- alu_operator_o  out  zpn_op_e  to ALU/mult
- alu_signed_operands_o  out  signed_type_e  to ALU/mult
- alu_operand_a_o  out  32  registered rs1
- alu_operand_b_o  out  32  registered rs2
- alu_enable_o  out  1  ALU enable
- mult_en_o  out  1  multiplier enable
- alu_result_i  in  32  ALU result (includes mult-based ops)
- alu_set_ov_i  in  1  ALU saturation flag
- result_valid_o  out  1  result available
- result_ready_i  in  1  writeback accepts
- result_o  out  32  captured result
- ov_o  out  1  sticky OV bit
- ov_clr_i  in  1  CSR write clears OV

Behaviour:
- Interface: one clock, clk_i; reset is asynchronous and active-low, rst_ni.
- Reset values:
  - state IDLE, so ready_o=1.
  - result_valid_o=0, result_o=0, ov_o=0.
  - All operand/operator registers 0; alu_enable_o=0, mult_en_o=0.
- States: IDLE, EXEC, MULT, DONE. ready_o = (state==IDLE).
- IDLE: on valid_i && ready_o (edge 0), register operator/signedness/operands. Next state is MULT if is_mult_op(operator_i), else EXEC.
- EXEC (cycle 1):
  - alu_enable_o=1.
  - On the edge, capture alu_result_i -> result_q and alu_set_ov_i -> ov_pend; go to DONE.
- MULT (cycles 1..MultCycles):
  - mult_en_o=1; a 4-bit counter counts up from 0.
  - alu_enable_o=1 only in the last cycle (cnt==MultCycles-1); capture there as in EXEC, then go to DONE.
- DONE:
  - result_valid_o=1 and result_o=result_q, both stable until result_ready_i.
  - On the handshake, go to IDLE. No new accept in the same cycle.
- Latency:
  - ALU op: result_valid_o in cycle 2.
  - Mult op: result_valid_o in cycle MultCycles+1.
- OV update:
  - ov_o |= ov_pend on the DONE handshake only.
  - If an ov_clr_i clear and a handshake set occur in the same cycle, the set wins (ov_o=1).
  - ov_clr_i in any other cycle clears ov_o.
- kill_i: in any non-IDLE state, go to IDLE next edge; result discarded, ov_o unchanged; mult_en_o/alu_enable_o drop that edge. kill_i in IDLE blocks the accept.
- Operand registers hold their values outside accept, so downstream inputs stay stable.
- Reset mid-op aborts immediately to reset values.

Optional Feature:
- Macro: PEXT_ALU_BYPASS_EN.
- Defined:
  - ALU (non-mult) ops skip DONE registration. In EXEC, result_valid_o=1 and result_o=alu_result_i combinationally, giving a 1-cycle latency.
  - If result_ready_i=0 in EXEC, capture into result_q and go to DONE as normal.
  - OV updates on the EXEC handshake.
- Undefined: behaviour as above.

Decomposition:
- ibex_pkg_pext gains:
  - issue_state_e (IDLE/EXEC/MULT/DONE).
  - function is_mult_op(zpn_op_e) returning 1 for multiplying operators.
- Reuses existing zpn_op_e and signed_type_e.
- Sub-module ibex_pext_ov_csr holds the sticky OV bit, its set/clear priority and the pending flag.

Test Plan:
- ALU op: accept ZPN_KCRSA16, a=32'h8201_11dc, b=32'h0505_7fca, stub returns 32'h01CB_0CD7, ov=0 -> alu_enable_o high in cycle 1 only; result_valid_o cycle 2 with 01CB_0CD7; ov_o=0.
- Mult op, MultCycles=2: stub returns 32'h0000_1234 with set_ov=1 -> mult_en_o high in cycles 1-2, alu_enable_o only in cycle 2; result_valid_o cycle 3; ov_o=1 after handshake.
- Backpressure: result_ready_i=0 for 3 cycles in DONE -> result_o stable, ready_o=0; accepts again the cycle after the handshake.
- kill_i in cycle 1 of a mult op -> mult_en_o=0 next cycle, no result_valid_o, ov_o unchanged, ready_o=1.
- ov_clr_i coincident with a handshake carrying set_ov=1 -> ov_o=1. ov_clr_i alone next cycle -> ov_o=0.
- Reset asserted in MULT -> outputs go to reset values immediately; first op after release completes normally.

Source files
------------

// File: rtl/ibex_pkg_pext.sv
//==============================================================================
// Module      : ibex_pkg_pext (package)
// Description : Shared types for the P-extension datapath. It holds the
//               operator and signedness encodings, the issue-stage state
//               encoding and the is_mult_op() classifier.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package ibex_pkg_pext;

    // P-extension operator encoding. This is the subset seen by the issue stage.
    typedef enum logic [4:0] {
        ZPN_ADD16   = 5'd0,
        ZPN_KADD16  = 5'd1,
        ZPN_KCRSA16 = 5'd2,
        ZPN_CRAS16  = 5'd3,
        ZPN_SMUL16  = 5'd4,
        ZPN_UMUL16  = 5'd5,
        ZPN_KMDA    = 5'd6,
        ZPN_SMAQA   = 5'd7,
        ZPN_KHM16   = 5'd8,
        ZPN_SMMUL   = 5'd9
    } zpn_op_e;

    // Element type and signedness.
    typedef enum logic [1:0] {
        ST_UNSIGNED = 2'd0,
        ST_SIGNED   = 2'd1,
        ST_MIXED    = 2'd2
    } signed_type_e;

    // States of the issue stage.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MULT = 2'd2,
        DONE = 2'd3
    } issue_state_e;

    // Returns 1 for operators that need the multi-cycle multiplier.
    function automatic logic is_mult_op(zpn_op_e op);
        logic r;
        case (op)
            ZPN_SMUL16, ZPN_UMUL16, ZPN_KMDA,
            ZPN_SMAQA,  ZPN_KHM16,  ZPN_SMMUL: r = 1'b1;
            default:                           r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ibex_pext_issue_ov_csr.sv
//==============================================================================
// Module      : ibex_pext_ov_csr
// Description : Sticky saturation (vxsat) bit for the P-extension issue stage.
//               It also holds the OV flag that is pending for the op in flight.
// Revision    : 1.0 - initial release
// Ports       : capture_i       - latch set_ov_i as the pending flag
//               set_ov_i        - ALU saturation flag
//               commit_i        - result handshake; merges OV into sticky bit
//               commit_direct_i - commit uses set_ov_i instead of the pending
//                                 flag (bypassed ALU result)
//               clr_i           - CSR write clearing the sticky bit
//               ov_o            - sticky OV bit
//==============================================================================
`default_nettype none

module ibex_pext_ov_csr (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic capture_i,
    input  logic set_ov_i,
    input  logic commit_i,
    input  logic commit_direct_i,
    input  logic clr_i,
    output logic ov_o
);

    logic ov_pend_q;
    logic ov_q;
    logic ov_d;
    logic w_set;

    assign w_set = commit_i && (commit_direct_i ? set_ov_i : ov_pend_q);

    // A set from a handshake takes priority over a simultaneous CSR clear.
    always_comb begin
        ov_d = ov_q;
        if (w_set) begin
            ov_d = 1'b1;
        end else if (clr_i) begin
            ov_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ov_pend_q <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            if (capture_i) begin
                ov_pend_q <= set_ov_i;
            end
            ov_q <= ov_d;
        end
    end

    assign ov_o = ov_q;

endmodule

`default_nettype wire

// File: rtl/ibex_pext_issue.sv
//==============================================================================
// Module      : ibex_pext_issue
// Description : Issue and sequencing stage in front of the P-extension ALU and
//               multiplier. It accepts one op at a time and registers its
//               operands. It drives the ALU or multiplier enables for the
//               required cycles, captures the result and OV flag, and presents
//               them to writeback.
// Revision    : 1.0 - initial release
// Config      : PEXT_ALU_BYPASS_EN - when defined, a non-mult result is offered
//               combinationally during EXEC, giving a 1-cycle latency.
// Ports       : valid_i/ready_o           - decoder handshake
//               kill_i                    - flush the in-flight op
//               operator_i, signed_operands_i, operand_a_i, operand_b_i - op in
//               alu_*_o, mult_en_o        - registered drive to ALU/mult
//               alu_result_i, alu_set_ov_i - ALU return path
//               result_valid_o/result_ready_i, result_o - writeback handshake
//               ov_o, ov_clr_i            - sticky vxsat bit and its clear
//==============================================================================
`default_nettype none

module ibex_pext_issue
    import ibex_pkg_pext::*;
#(
    parameter int unsigned MultCycles = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic         kill_i,
    input  zpn_op_e      operator_i,
    input  signed_type_e signed_operands_i,
    input  logic [31:0]  operand_a_i,
    input  logic [31:0]  operand_b_i,
    output zpn_op_e      alu_operator_o,
    output signed_type_e alu_signed_operands_o,
    output logic [31:0]  alu_operand_a_o,
    output logic [31:0]  alu_operand_b_o,
    output logic         alu_enable_o,
    output logic         mult_en_o,
    input  logic [31:0]  alu_result_i,
    input  logic         alu_set_ov_i,
    output logic         result_valid_o,
    input  logic         result_ready_i,
    output logic [31:0]  result_o,
    output logic         ov_o,
    input  logic         ov_clr_i
);

`ifdef PEXT_ALU_BYPASS_EN
    localparam bit BypassEn = 1'b1;
`else
    localparam bit BypassEn = 1'b0;
`endif

    // Counter value of the last multiplier cycle.
    localparam logic [3:0] LastCnt = 4'(MultCycles - 1);

    issue_state_e state_q;
    zpn_op_e      operator_q;
    signed_type_e signed_q;
    logic [31:0]  op_a_q;
    logic [31:0]  op_b_q;
    logic [31:0]  result_q;
    logic [3:0]   cnt_q;
    logic         alu_en_q;
    logic         mult_en_q;
    logic         result_valid_q;

    logic w_bypass;
    logic w_capture;
    logic w_commit;

    assign w_bypass = BypassEn && (state_q == EXEC);

    // Points where the ALU output is sampled into the result/pending OV.
    assign w_capture = !kill_i &&
                       ((state_q == EXEC) || ((state_q == MULT) && (cnt_q == LastCnt)));

    assign w_commit = !kill_i && result_ready_i &&
                      ((state_q == DONE) || w_bypass);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            operator_q     <= ZPN_ADD16;
            signed_q       <= ST_UNSIGNED;
            op_a_q         <= 32'd0;
            op_b_q         <= 32'd0;
            result_q       <= 32'd0;
            cnt_q          <= 4'd0;
            alu_en_q       <= 1'b0;
            mult_en_q      <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i && !kill_i) begin
                        operator_q <= operator_i;
                        signed_q   <= signed_operands_i;
                        op_a_q     <= operand_a_i;
                        op_b_q     <= operand_b_i;
                        cnt_q      <= 4'd0;
                        if (is_mult_op(operator_i)) begin
                            state_q   <= MULT;
                            mult_en_q <= 1'b1;
                            // A single-cycle multiply also enables the ALU at once.
                            alu_en_q  <= (LastCnt == 4'd0);
                        end else begin
                            state_q  <= EXEC;
                            alu_en_q <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    alu_en_q <= 1'b0;
                    if (kill_i) begin
                        state_q <= IDLE;
                    end else if (w_bypass && result_ready_i) begin
                        // Result was taken straight from the ALU.
                        state_q <= IDLE;
                    end else begin
                        result_q       <= alu_result_i;
                        result_valid_q <= 1'b1;
                        state_q        <= DONE;
                    end
                end
                MULT: begin
                    if (kill_i) begin
                        state_q   <= IDLE;
                        mult_en_q <= 1'b0;
                        alu_en_q  <= 1'b0;
                    end else if (cnt_q == LastCnt) begin
                        result_q       <= alu_result_i;
                        result_valid_q <= 1'b1;
                        mult_en_q      <= 1'b0;
                        alu_en_q       <= 1'b0;
                        state_q        <= DONE;
                    end else begin
                        cnt_q    <= cnt_q + 4'd1;
                        alu_en_q <= ((cnt_q + 4'd1) == LastCnt);
                    end
                end
                DONE: begin
                    if (kill_i || result_ready_i) begin
                        result_valid_q <= 1'b0;
                        state_q        <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    ibex_pext_ov_csr u_ov_csr (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .capture_i      (w_capture),
        .set_ov_i       (alu_set_ov_i),
        .commit_i       (w_commit),
        .commit_direct_i(w_bypass),
        .clr_i          (ov_clr_i),
        .ov_o           (ov_o)
    );

    assign ready_o               = (state_q == IDLE);
    assign alu_operator_o        = operator_q;
    assign alu_signed_operands_o = signed_q;
    assign alu_operand_a_o       = op_a_q;
    assign alu_operand_b_o       = op_b_q;
    assign alu_enable_o          = alu_en_q;
    assign mult_en_o             = mult_en_q;
    assign result_valid_o        = result_valid_q | w_bypass;
    assign result_o              = w_bypass ? alu_result_i : result_q;

endmodule

`default_nettype wire

// File: tb/tb_ibex_pext_issue.sv
//==============================================================================
// Module      : tb_ibex_pext_issue
// Description : Directed self-checking bench for ibex_pext_issue (default
//               build, MultCycles = 2). Outputs are sampled on the falling
//               edge and new inputs are driven right after each check.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ibex_pext_issue;
    import ibex_pkg_pext::*;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         valid_i;
    logic         ready_o;
    logic         kill_i;
    zpn_op_e      operator_i;
    signed_type_e signed_operands_i;
    logic [31:0]  operand_a_i;
    logic [31:0]  operand_b_i;
    zpn_op_e      alu_operator_o;
    signed_type_e alu_signed_operands_o;
    logic [31:0]  alu_operand_a_o;
    logic [31:0]  alu_operand_b_o;
    logic         alu_enable_o;
    logic         mult_en_o;
    logic [31:0]  alu_result_i;
    logic         alu_set_ov_i;
    logic         result_valid_o;
    logic         result_ready_i;
    logic [31:0]  result_o;
    logic         ov_o;
    logic         ov_clr_i;

    int tests = 0;
    int fails = 0;

    ibex_pext_issue #(.MultCycles(2)) dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .valid_i              (valid_i),
        .ready_o              (ready_o),
        .kill_i               (kill_i),
        .operator_i           (operator_i),
        .signed_operands_i    (signed_operands_i),
        .operand_a_i          (operand_a_i),
        .operand_b_i          (operand_b_i),
        .alu_operator_o       (alu_operator_o),
        .alu_signed_operands_o(alu_signed_operands_o),
        .alu_operand_a_o      (alu_operand_a_o),
        .alu_operand_b_o      (alu_operand_b_o),
        .alu_enable_o         (alu_enable_o),
        .mult_en_o            (mult_en_o),
        .alu_result_i         (alu_result_i),
        .alu_set_ov_i         (alu_set_ov_i),
        .result_valid_o       (result_valid_o),
        .result_ready_i       (result_ready_i),
        .result_o             (result_o),
        .ov_o                 (ov_o),
        .ov_clr_i             (ov_clr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_ni = 1'b0; valid_i = 1'b0; kill_i = 1'b0;
        operator_i = ZPN_ADD16; signed_operands_i = ST_UNSIGNED;
        operand_a_i = '0; operand_b_i = '0;
        alu_result_i = '0; alu_set_ov_i = 1'b0;
        result_ready_i = 1'b0; ov_clr_i = 1'b0;
        step(); step();

        // Reset values
        chk("rst_ready",  32'(ready_o), 32'd1);
        chk("rst_rvalid", 32'(result_valid_o), 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_ov",     32'(ov_o), 32'd0);
        chk("rst_alu_en", 32'(alu_enable_o), 32'd0);
        chk("rst_mult",   32'(mult_en_o), 32'd0);
        chk("rst_opa",    alu_operand_a_o, 32'd0);
        rst_ni = 1'b1;

        // ALU op: KCRSA16
        valid_i = 1'b1; operator_i = ZPN_KCRSA16; signed_operands_i = ST_SIGNED;
        operand_a_i = 32'h8201_11dc; operand_b_i = 32'h0505_7fca;
        chk("alu_c0_ready", 32'(ready_o), 32'd1);
        step();
        valid_i = 1'b0;
        chk("alu_c1_alu_en", 32'(alu_enable_o), 32'd1);
        chk("alu_c1_mult",   32'(mult_en_o), 32'd0);
        chk("alu_c1_ready",  32'(ready_o), 32'd0);
        chk("alu_c1_rvalid", 32'(result_valid_o), 32'd0);
        chk("alu_c1_opa",    alu_operand_a_o, 32'h8201_11dc);
        chk("alu_c1_opb",    alu_operand_b_o, 32'h0505_7fca);
        chk("alu_c1_oper",   32'(alu_operator_o), 32'(ZPN_KCRSA16));
        chk("alu_c1_sign",   32'(alu_signed_operands_o), 32'(ST_SIGNED));
        alu_result_i = 32'h01CB_0CD7; alu_set_ov_i = 1'b0; result_ready_i = 1'b1;
        step();
        chk("alu_c2_rvalid", 32'(result_valid_o), 32'd1);
        chk("alu_c2_result", result_o, 32'h01CB_0CD7);
        chk("alu_c2_alu_en", 32'(alu_enable_o), 32'd0);
        step();
        chk("alu_c3_rvalid", 32'(result_valid_o), 32'd0);
        chk("alu_c3_ready",  32'(ready_o), 32'd1);
        chk("alu_c3_ov",     32'(ov_o), 32'd0);
        result_ready_i = 1'b0;

        // Mult op with saturation
        valid_i = 1'b1; operator_i = ZPN_SMUL16;
        operand_a_i = 32'h0003_0004; operand_b_i = 32'h0005_0006;
        step();
        valid_i = 1'b0;
        chk("mul_c1_mult",   32'(mult_en_o), 32'd1);
        chk("mul_c1_alu_en", 32'(alu_enable_o), 32'd0);
        chk("mul_c1_rvalid", 32'(result_valid_o), 32'd0);
        alu_result_i = 32'h0000_1234; alu_set_ov_i = 1'b1;
        step();
        chk("mul_c2_mult",   32'(mult_en_o), 32'd1);
        chk("mul_c2_alu_en", 32'(alu_enable_o), 32'd1);
        chk("mul_c2_rvalid", 32'(result_valid_o), 32'd0);
        step();
        alu_result_i = 32'hDEAD_BEEF; alu_set_ov_i = 1'b0;
        chk("mul_c3_rvalid", 32'(result_valid_o), 32'd1);
        chk("mul_c3_result", result_o, 32'h0000_1234);
        chk("mul_c3_mult",   32'(mult_en_o), 32'd0);
        chk("mul_c3_alu_en", 32'(alu_enable_o), 32'd0);
        chk("mul_c3_ov",     32'(ov_o), 32'd0);
        result_ready_i = 1'b1;
        step();
        chk("mul_c4_ov",     32'(ov_o), 32'd1);
        chk("mul_c4_rvalid", 32'(result_valid_o), 32'd0);
        chk("mul_c4_ready",  32'(ready_o), 32'd1);
        result_ready_i = 1'b0;

        // Backpressure in DONE
        valid_i = 1'b1; operator_i = ZPN_ADD16; signed_operands_i = ST_UNSIGNED;
        operand_a_i = 32'h0000_0001; operand_b_i = 32'h0000_0002;
        step();
        valid_i = 1'b0;
        alu_result_i = 32'hCAFE_F00D; alu_set_ov_i = 1'b0;
        step();
        chk("bp_c2_rvalid", 32'(result_valid_o), 32'd1);
        chk("bp_c2_result", result_o, 32'hCAFE_F00D);
        alu_result_i = 32'h1111_1111;
        valid_i = 1'b1; operator_i = ZPN_CRAS16; operand_a_i = 32'hA5A5_0001;
        step();
        chk("bp_c3_rvalid", 32'(result_valid_o), 32'd1);
        chk("bp_c3_result", result_o, 32'hCAFE_F00D);
        chk("bp_c3_ready",  32'(ready_o), 32'd0);
        step();
        chk("bp_c4_rvalid", 32'(result_valid_o), 32'd1);
        chk("bp_c4_result", result_o, 32'hCAFE_F00D);
        chk("bp_c4_ready",  32'(ready_o), 32'd0);
        chk("bp_c4_opa",    alu_operand_a_o, 32'h0000_0001);
        result_ready_i = 1'b1;
        step();
        chk("bp_c5_ready",  32'(ready_o), 32'd1);
        chk("bp_c5_rvalid", 32'(result_valid_o), 32'd0);
        chk("bp_c5_ov",     32'(ov_o), 32'd1);
        step();
        valid_i = 1'b0;
        chk("bp_c6_alu_en", 32'(alu_enable_o), 32'd1);
        chk("bp_c6_opa",    alu_operand_a_o, 32'hA5A5_0001);
        alu_result_i = 32'h0000_0000;
        step();
        chk("bp_c7_rvalid", 32'(result_valid_o), 32'd1);
        step();
        result_ready_i = 1'b0;

        // CSR clear on its own
        ov_clr_i = 1'b1;
        step();
        ov_clr_i = 1'b0;
        chk("clr_ov", 32'(ov_o), 32'd0);

        // kill in IDLE blocks the accept
        valid_i = 1'b1; kill_i = 1'b1; operator_i = ZPN_ADD16;
        step();
        valid_i = 1'b0; kill_i = 1'b0;
        chk("kidle_alu_en", 32'(alu_enable_o), 32'd0);
        chk("kidle_ready",  32'(ready_o), 32'd1);

        // kill in the first cycle of a mult op
        valid_i = 1'b1; operator_i = ZPN_SMUL16;
        step();
        valid_i = 1'b0;
        chk("kill_c1_mult", 32'(mult_en_o), 32'd1);
        kill_i = 1'b1; alu_set_ov_i = 1'b1; alu_result_i = 32'h7777_7777;
        step();
        kill_i = 1'b0; alu_set_ov_i = 1'b0;
        chk("kill_c2_mult",   32'(mult_en_o), 32'd0);
        chk("kill_c2_alu_en", 32'(alu_enable_o), 32'd0);
        chk("kill_c2_ready",  32'(ready_o), 32'd1);
        chk("kill_c2_rvalid", 32'(result_valid_o), 32'd0);
        result_ready_i = 1'b1;
        step();
        chk("kill_c3_rvalid", 32'(result_valid_o), 32'd0);
        chk("kill_c3_ov",     32'(ov_o), 32'd0);
        result_ready_i = 1'b0;

        // Clear coincident with a saturating handshake: set wins
        valid_i = 1'b1; operator_i = ZPN_KMDA;
        step();
        valid_i = 1'b0;
        alu_result_i = 32'h5555_5555; alu_set_ov_i = 1'b1;
        step();
        step();
        alu_set_ov_i = 1'b0;
        chk("coin_c3_rvalid", 32'(result_valid_o), 32'd1);
        result_ready_i = 1'b1; ov_clr_i = 1'b1;
        step();
        chk("coin_ov_set", 32'(ov_o), 32'd1);
        result_ready_i = 1'b0; ov_clr_i = 1'b1;
        step();
        chk("coin_ov_clr", 32'(ov_o), 32'd0);
        ov_clr_i = 1'b0;

        // Asynchronous reset during MULT
        valid_i = 1'b1; operator_i = ZPN_SMUL16; operand_a_i = 32'h0000_FFFF;
        step();
        valid_i = 1'b0;
        chk("rmul_c1_mult", 32'(mult_en_o), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("rmul_mult",   32'(mult_en_o), 32'd0);
        chk("rmul_ready",  32'(ready_o), 32'd1);
        chk("rmul_opa",    alu_operand_a_o, 32'd0);
        chk("rmul_rvalid", 32'(result_valid_o), 32'd0);
        chk("rmul_result", result_o, 32'd0);
        step();
        rst_ni = 1'b1;
        valid_i = 1'b1; operator_i = ZPN_ADD16; operand_a_i = 32'h0000_0042;
        step();
        valid_i = 1'b0;
        chk("post_c1_alu_en", 32'(alu_enable_o), 32'd1);
        chk("post_c1_opa",    alu_operand_a_o, 32'h0000_0042);
        alu_result_i = 32'h0BAD_F00D; result_ready_i = 1'b1;
        step();
        chk("post_c2_rvalid", 32'(result_valid_o), 32'd1);
        chk("post_c2_result", result_o, 32'h0BAD_F00D);
        step();
        chk("post_c3_ready", 32'(ready_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
